sa_wdata_order_arb: RTL and testbench

Slave-side write-data arbiter for the AXI4 interconnect: shares one slave's W channel between the per-master W dispatchers. It grants W bursts strictly in the order the slave's AW arbiter accepted write addresses, holds each grant until the WLAST handshake, and then advances to the next queued master. It sits between the master-side W dispatchers and the slave port, one instance per slave.

---
 rtl/sa_wdata_order_pkg.sv | 19 +
 rtl/sa_wdata_order_arb_sync_fifo.sv | 54 +++++
 rtl/sa_wdata_order_arb.sv | 129 ++++++++++++
 tb/tb_sa_wdata_order_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sa_wdata_order_pkg.sv
// Shared types and defaults for the slave-side W-channel order arbiter.
package sa_wdata_order_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wst_e;

    localparam int ORD_DEPTH_DEF = 4;
    localparam int LEN_W_DEF     = 8;
    // Widest master index an order entry can carry (up to 16 masters).
    localparam int ORD_ID_W      = 4;

    typedef struct packed {
        logic [ORD_ID_W-1:0]  mst_id;
        logic [LEN_W_DEF-1:0] len;
    } ord_entry_t;

endpackage

// File: rtl/sa_wdata_order_arb_sync_fifo.sv
// Synchronous FIFO whose head entry comes straight from registers; data storage is not reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sa_wdata_order_arb.sv
// Grants a slave's W channel to masters in AW-acceptance order, one burst per order entry.
// Optional burst-length checking is enabled with the SA_WDATA_LEN_CHECK_EN macro.
module sa_wdata_order_arb
    import sa_wdata_order_pkg::*;
#(
    parameter int MST_AMT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MST_ID_W   = $clog2(MST_AMT),
    parameter int ORD_DEPTH  = ORD_DEPTH_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic [MST_ID_W-1:0]           aw_grant_mst_id_i,
    input  logic [LEN_W-1:0]              aw_grant_len_i,
    input  logic                          aw_grant_valid_i,
    output logic                          aw_grant_ready_o,
    input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
    input  logic [MST_AMT-1:0]            dsp_WLAST_i,
    input  logic [MST_AMT-1:0]            dsp_WVALID_i,
    input  logic [MST_AMT-1:0]            dsp_WDATA_sel_i,
    output logic [MST_AMT-1:0]            dsp_WREADY_o,
    output logic [DATA_WIDTH-1:0]         s_WDATA_o,
    output logic                          s_WLAST_o,
    output logic                          s_WVALID_o,
    input  logic                          s_WREADY_i,
    output logic                          w_len_err_o
);

    localparam int CNT_W = $clog2(ORD_DEPTH) + 1;

    wst_e                state_q, state_d;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push, pop, hv, hs;
    logic [ORD_ID_W-1:0] head_id_raw;
    logic [MST_ID_W-1:0] h;

`ifdef SA_WDATA_LEN_CHECK_EN
    localparam int ENT_W = $bits(ord_entry_t);
    ord_entry_t push_ent, head_ent;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] head_len;
    logic             len_err_q;

    assign push_ent.mst_id = ORD_ID_W'(aw_grant_mst_id_i);
    assign push_ent.len    = LEN_W_DEF'(aw_grant_len_i);
    assign head_id_raw     = head_ent.mst_id;
    assign head_len        = LEN_W'(head_ent.len);
    assign w_len_err_o     = len_err_q;

    // Beat counter restarts on every WLAST so each burst is judged on its own.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else if (hs) begin
            beat_cnt <= s_WLAST_o ? '0 : beat_cnt + LEN_W'(1);
            if (( s_WLAST_o && (beat_cnt != head_len)) ||
                (!s_WLAST_o && (beat_cnt == head_len)))
                len_err_q <= 1'b1;
        end
    end
`else
    localparam int ENT_W = ORD_ID_W;
    logic [ORD_ID_W-1:0] push_ent, head_ent;
    logic                unused_len;

    assign push_ent    = ORD_ID_W'(aw_grant_mst_id_i);
    assign head_id_raw = head_ent;
    assign unused_len  = ^aw_grant_len_i;
    assign w_len_err_o = 1'b0;
`endif

    logic unused_head;
    assign unused_head = ^head_ent;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (ORD_DEPTH),
        .CNT_W (CNT_W)
    ) u_ord_fifo (
        .clk   (ACLK_i),
        .rst_n (ARESETn_i),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head_ent),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign aw_grant_ready_o = ~fifo_full;
    assign push             = aw_grant_valid_i & aw_grant_ready_o;
    assign hv               = (state_q == BURST);
    // With no valid head, the mux parks on master 0.
    assign h                = hv ? MST_ID_W'(head_id_raw) : '0;

    assign s_WDATA_o  = dsp_WDATA_i[DATA_WIDTH*h +: DATA_WIDTH];
    assign s_WLAST_o  = dsp_WLAST_i[h];
    assign s_WVALID_o = hv & dsp_WVALID_i[h] & dsp_WDATA_sel_i[h];
    assign hs         = s_WVALID_o & s_WREADY_i;
    assign pop        = hs & s_WLAST_o;

    always_comb begin
        dsp_WREADY_o = '0;
        for (int m = 0; m < MST_AMT; m++)
            dsp_WREADY_o[m] = hv & (h == MST_ID_W'(m)) & dsp_WDATA_sel_i[m] & s_WREADY_i;
    end

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = BURST;
            BURST:   if (pop && !push && (fifo_count == CNT_W'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic unused_empty;
    assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_sa_wdata_order_arb.sv
// Directed self-checking bench for sa_wdata_order_arb (2 masters, 32-bit data, 4-deep order FIFO).
module tb_sa_wdata_order_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  gid;
    logic [7:0]  glen;
    logic        gvalid;
    logic        gready;
    logic [63:0] wdata;
    logic [1:0]  wlast, wvalid, wsel, wready;
    logic [31:0] s_wdata;
    logic        s_wlast, s_wvalid, s_wready, len_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sa_wdata_order_arb dut (
        .ACLK_i            (clk),
        .ARESETn_i         (rst_n),
        .aw_grant_mst_id_i (gid),
        .aw_grant_len_i    (glen),
        .aw_grant_valid_i  (gvalid),
        .aw_grant_ready_o  (gready),
        .dsp_WDATA_i       (wdata),
        .dsp_WLAST_i       (wlast),
        .dsp_WVALID_i      (wvalid),
        .dsp_WDATA_sel_i   (wsel),
        .dsp_WREADY_o      (wready),
        .s_WDATA_o         (s_wdata),
        .s_WLAST_o         (s_wlast),
        .s_WVALID_o        (s_wvalid),
        .s_WREADY_i        (s_wready),
        .w_len_err_o       (len_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic id, input logic [7:0] len);
        gid = id; glen = len; gvalid = 1'b1;
        tick();
        gvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; gid = '0; glen = '0; gvalid = 1'b0;
        wdata = '0; wlast = '0; wvalid = '0; wsel = '0; s_wready = 1'b0;
        tick(); tick();
        check("rst_ready", gready, 1);
        check("rst_wvalid", s_wvalid, 0);
        check("rst_wready", wready, 0);
        check("rst_err", len_err, 0);
        rst_n = 1'b1;
        tick();

        // Single burst from master 1, len=3.
        wsel = 2'b11; wvalid = 2'b10; s_wready = 1'b1; wdata[63:32] = 32'hA0;
        gid = 1'b1; glen = 8'd3; gvalid = 1'b1;
        #1;
        check("single_push_cycle_wvalid", s_wvalid, 0);
        tick();
        gvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wdata[63:32] = 32'hA0 + b;
            wlast = (b == 3) ? 2'b10 : 2'b00;
            #1;
            check("single_wvalid", s_wvalid, 1);
            check("single_wdata", s_wdata, 64'hA0 + b);
            check("single_wready", wready, 2'b10);
            check("single_wlast", s_wlast, (b == 3));
            tick();
        end
        wlast = '0;
        #1;
        check("single_done_wvalid", s_wvalid, 0);
        check("single_done_wready", wready, 0);

        // Ordering: pushes 1,0,1 with both masters valid.
        s_wready = 1'b0; wvalid = 2'b11; wdata = {32'hC1, 32'hB0};
        push1(1'b1, 8'd1); push1(1'b0, 8'd1); push1(1'b1, 8'd1);
        s_wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [1:0] e1h;
            e1h = (k == 1) ? 2'b01 : 2'b10;
            for (int b = 0; b < 2; b++) begin
                wlast = (b == 1) ? 2'b11 : 2'b00;
                #1;
                check("order_wdata", s_wdata, (k == 1) ? 64'hB0 : 64'hC1);
                check("order_wready", wready, e1h);
                tick();
            end
        end
        wlast = '0;
        #1;
        check("order_done_wvalid", s_wvalid, 0);

        // Backpressure on a 2-beat burst from master 0.
        s_wready = 1'b0; wvalid = 2'b01;
        push1(1'b0, 8'd1);
        wdata[31:0] = 32'hD0; s_wready = 1'b1; #1;
        check("bp_b0_wready", wready, 2'b01);
        tick();
        wdata[31:0] = 32'hD1; wlast = 2'b01;
        for (int c = 0; c < 3; c++) begin
            s_wready = (c == 2);
            #1;
            check("bp_wvalid", s_wvalid, 1);
            check("bp_wdata", s_wdata, 64'hD1);
            check("bp_wready", wready, (c == 2) ? 2'b01 : 2'b00);
            tick();
        end
        wlast = '0;
        #1;
        check("bp_done_wvalid", s_wvalid, 0);

        // Full FIFO: 4 pushes, 5th refused even alongside a pop.
        wvalid = 2'b00; s_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("full_ready_before", gready, 1);
            push1(i[0], 8'd0);
        end
        check("full_ready", gready, 0);
        wvalid = 2'b11; wlast = 2'b11; s_wready = 1'b1;
        gid = 1'b0; gvalid = 1'b1;
        #1;
        check("full_pop0_wready", wready, 2'b01);
        tick();
        gvalid = 1'b0;
        check("full_ready_after_pop", gready, 1);
        for (int k = 0; k < 3; k++) begin
            check("full_drain_wready", wready, (k == 1) ? 2'b01 : 2'b10);
            tick();
        end
        check("full_fifth_ignored", s_wvalid, 0);
        wlast = '0;

        // Length check: len=1 burst sent with 3 beats.
        wvalid = 2'b01; s_wready = 1'b0;
        push1(1'b0, 8'd1);
        s_wready = 1'b1;
        tick();
        check("len_err_beat1", len_err, 0);
        tick();
`ifdef SA_WDATA_LEN_CHECK_EN
        check("len_err_beat2", len_err, 1);
`else
        check("len_err_beat2", len_err, 0);
`endif
        wlast = 2'b01;
        tick();
        wlast = '0;
`ifdef SA_WDATA_LEN_CHECK_EN
        check("len_err_sticky", len_err, 1);
`else
        check("len_err_sticky", len_err, 0);
`endif
        check("len_popped", s_wvalid, 0);

        // Reset in the middle of a burst.
        wvalid = 2'b10; s_wready = 1'b0;
        push1(1'b1, 8'd3);
        s_wready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_beat2_wvalid", s_wvalid, 1);
        tick();
        check("mid_rst_wvalid", s_wvalid, 0);
        check("mid_rst_ready", gready, 1);
        check("mid_rst_err", len_err, 0);
        check("mid_rst_wready", wready, 0);
        rst_n = 1'b1;
        tick();
        check("mid_flushed", s_wvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
